avalon_write_master: RTL and testbench
======================================

Name: avalon_write_master

Overview:
- Avalon-MM write master that sits directly downstream of user_logic.
- Consumes user_logic's write control interface (go, base, length, fixed_location) and its user data interface (write_buffer, buffer_data).
- Buffers write data in an internal FIFO and issues single-word Avalon-MM writes to the fabric.
- Returns control_done and user_buffer_full to user_logic.

Parameters:
ADDRESSWIDTH, 28, width of byte address and length
DATAWIDTH, 32, data word width
BYTEENABLEWIDTH, 4, bytes per word (DATAWIDTH/8)
FIFODEPTH, 32, write-data FIFO depth in words (power of 2, >=2)
FIFODEPTH_LOG2, 5, log2(FIFODEPTH)

Ports:
clk  input  1  system clock
reset  input  1  asynchronous active-low reset
control_fixed_location  input  1  1 = do not increment address between words
control_write_base  input  ADDRESSWIDTH  start byte address, sampled on accepted go
control_write_length  input  ADDRESSWIDTH  bytes to transfer, sampled on accepted go
control_go  input  1  single-cycle start pulse
control_done  output  1  high and held while no transfer is outstanding
user_write_buffer  input  1  push user_buffer_data into FIFO
user_buffer_data  input  DATAWIDTH  write data
user_buffer_full  output  1  FIFO full; pushes are dropped
master_address  output  ADDRESSWIDTH  Avalon byte address
master_write  output  1  Avalon write request
master_byteenable  output  BYTEENABLEWIDTH  always all ones
master_writedata  output  DATAWIDTH  FIFO head word
master_waitrequest  input  1  slave stall

Behaviour:
- Reset (reset low, asynchronous):
  - State IDLE, FIFO emptied, address 0, remaining 0.
  - master_write 0, control_done 1, user_buffer_full 0.
  - Reset mid-transfer aborts immediately; master_write drops in the same instant without waiting for waitrequest.
- States: IDLE and BUSY.
- IDLE:
  - control_go=1 latches base into the address register, length[ADDRESSWIDTH-1:log2(BYTEENABLEWIDTH)] word-aligned into remaining, and fixed_location; state goes to BUSY.
  - Length low bits (non-multiple of BYTEENABLEWIDTH) are truncated.
  - Length 0: go is accepted, state stays IDLE, control_done stays 1.
- BUSY:
  - go is ignored.
  - When remaining reaches 0, state returns to IDLE on the next edge.
- control_done = (state==IDLE). It falls the cycle after the go edge and rises the cycle after the final accepted word.
- master_write = (state==BUSY) & FIFO not empty & remaining!=0. It is driven from registered state only, with no combinational path from master_waitrequest.
- master_writedata = FIFO head (show-ahead). master_byteenable = all ones.
- Accepted word = master_write & !master_waitrequest. On an accepted word:
  - FIFO pops.
  - remaining decrements by BYTEENABLEWIDTH.
  - Address increments by BYTEENABLEWIDTH unless fixed_location; address wraps modulo 2^ADDRESSWIDTH.
- While master_waitrequest=1: address, writedata and write are held stable.
- FIFO push:
  - Happens when user_write_buffer=1 and user_buffer_full=0, in any state. Data pushed in IDLE is held for the next transfer.
  - Push while full is dropped silently.
  - user_buffer_full = (count==FIFODEPTH). A same-cycle pop does not allow a push when full.
  - Simultaneous push and pop when neither full nor empty leaves count unchanged.
- FIFO empty in BUSY: master_write drops and the master waits; no error is raised.
- Latency: with go and push in cycle 0 and waitrequest=0:
  - master_write is high in cycle 1.
  - control_done is high in cycle 2.
- Words left in the FIFO after remaining hits 0 stay queued for the next go.

Decomposition:
- Shared package write_master_pkg holds wm_state_t (IDLE, BUSY) and the byteenable-all-ones constant function.
- One sub-module, wm_fifo: synchronous show-ahead FIFO with ports clk, reset, push, pop, din, dout, empty, full and a count of width FIFODEPTH_LOG2+1.
- Pointer/count logic lives in wm_fifo. The FSM and address/remaining counters live in the top.

Test Plan:
- Single word: go with base 0x0000010, length 4, fixed=1, and push 0xF00FBEEB in the same cycle; waitrequest=0 -> one write at 0x0000010 with data 0xF00FBEEB in cycle 1; control_done low in cycle 1, high in cycle 2.
- Waitrequest stall: same as the single-word case with waitrequest high for 3 cycles -> address and data held for 4 cycles; exactly one accepted write; done rises the cycle after acceptance.
- Incrementing burst: base 0x0000100, length 16, fixed=0, push 1,2,3,4 -> writes at 0x100/0x104/0x108/0x10C with data 1..4; the FIFO is then empty.
- Full/drop: push 33 words while IDLE with FIFODEPTH=32 -> full asserts after the 32nd push; the 33rd is dropped; a subsequent length-128 transfer writes words 1..32 only.
- Edge cases: go with length 0 -> done never falls and no write; go in BUSY -> ignored; base 0xFFFFFFC with length 8 -> second address wraps to 0x0000000.
- Reset mid-transfer: drop reset during a 4-word transfer after 2 words -> master_write 0 immediately, done 1, FIFO empty; a new 1-word transfer after release completes normally.

Source files
------------

// File: rtl/write_master_pkg.sv
// ----------------------------------------------------------------------------
// write_master_pkg
// Shared types and helpers for the Avalon-MM write master.
//   wm_state_t  : transfer FSM states (IDLE, BUSY)
//   be_all_ones : builds an all-ones byteenable mask of a given width
// ----------------------------------------------------------------------------
package write_master_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } wm_state_t;

    // Widest byteenable the helper can produce; callers cast down to their width.
    localparam int MAX_BE_WIDTH = 64;

    function automatic logic [MAX_BE_WIDTH-1:0] be_all_ones(input int width);
        logic [MAX_BE_WIDTH-1:0] mask;
        mask = '0;
        for (int i = 0; i < MAX_BE_WIDTH; i++) begin
            if (i < width) begin
                mask[i] = 1'b1;
            end
        end
        return mask;
    endfunction

endpackage

// File: rtl/wm_fifo.sv
// ----------------------------------------------------------------------------
// wm_fifo
// Synchronous show-ahead FIFO holding write data for the Avalon write master.
// dout always presents the head word; pop advances to the next one.
//   clk, reset : clock, asynchronous active-low reset (empties the FIFO)
//   push, din  : write request and data (ignored while full)
//   pop        : consume head word (ignored while empty)
//   dout       : head word
//   empty/full : occupancy flags
//   count      : number of stored words (0..FIFODEPTH)
// ----------------------------------------------------------------------------
module wm_fifo
    import write_master_pkg::*;
#(
    parameter int DATAWIDTH      = 32,
    parameter int FIFODEPTH      = 32,
    parameter int FIFODEPTH_LOG2 = 5
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      push,
    input  logic                      pop,
    input  logic [DATAWIDTH-1:0]      din,
    output logic [DATAWIDTH-1:0]      dout,
    output logic                      empty,
    output logic                      full,
    output logic [FIFODEPTH_LOG2:0]   count
);

    localparam logic [FIFODEPTH_LOG2-1:0] PTR_ONE   = {{(FIFODEPTH_LOG2-1){1'b0}}, 1'b1};
    localparam logic [FIFODEPTH_LOG2:0]   CNT_ONE   = {{FIFODEPTH_LOG2{1'b0}}, 1'b1};
    localparam logic [FIFODEPTH_LOG2:0]   CNT_DEPTH = (FIFODEPTH_LOG2+1)'(FIFODEPTH);

    logic [DATAWIDTH-1:0]      mem_q [FIFODEPTH];
    logic [FIFODEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [FIFODEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [FIFODEPTH_LOG2:0]   count_q,  count_d;
    logic                      push_ok;
    logic                      pop_ok;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CNT_DEPTH);
    assign count   = count_q;
    assign dout    = mem_q[rd_ptr_q];

    // A push while full is dropped even if a pop happens in the same cycle.
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;

    // Pointers wrap naturally because the depth is a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset; stale words are never visible once pointers clear.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

endmodule

// File: rtl/avalon_write_master.sv
// ----------------------------------------------------------------------------
// avalon_write_master
// Buffers user write data in a FIFO and issues single-word Avalon-MM writes.
//   clk, reset                    : clock, asynchronous active-low reset
//   control_go/_write_base/_write_length/_fixed_location : transfer request
//   control_done                  : high while no transfer is outstanding
//   user_write_buffer/_buffer_data: FIFO push interface
//   user_buffer_full              : FIFO full, pushes are dropped
//   master_*                      : Avalon-MM write master port
// ----------------------------------------------------------------------------
module avalon_write_master
    import write_master_pkg::*;
#(
    parameter int ADDRESSWIDTH    = 28,
    parameter int DATAWIDTH       = 32,
    parameter int BYTEENABLEWIDTH = 4,
    parameter int FIFODEPTH       = 32,
    parameter int FIFODEPTH_LOG2  = 5
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       control_fixed_location,
    input  logic [ADDRESSWIDTH-1:0]    control_write_base,
    input  logic [ADDRESSWIDTH-1:0]    control_write_length,
    input  logic                       control_go,
    output logic                       control_done,
    input  logic                       user_write_buffer,
    input  logic [DATAWIDTH-1:0]       user_buffer_data,
    output logic                       user_buffer_full,
    output logic [ADDRESSWIDTH-1:0]    master_address,
    output logic                       master_write,
    output logic [BYTEENABLEWIDTH-1:0] master_byteenable,
    output logic [DATAWIDTH-1:0]       master_writedata,
    input  logic                       master_waitrequest
);

    localparam logic [ADDRESSWIDTH-1:0]   WORD_BYTES = ADDRESSWIDTH'(BYTEENABLEWIDTH);
    localparam logic [ADDRESSWIDTH-1:0]   ALIGN_MASK = ~(WORD_BYTES - 1'b1);
    localparam logic [FIFODEPTH_LOG2:0]   CNT_DEPTH  = (FIFODEPTH_LOG2+1)'(FIFODEPTH);

    wm_state_t                 state_q, state_d;
    logic [ADDRESSWIDTH-1:0]   addr_q, addr_d;
    logic [ADDRESSWIDTH-1:0]   remaining_q, remaining_d;
    logic                      fixed_q, fixed_d;
    logic [ADDRESSWIDTH-1:0]   aligned_length;
    logic                      fifo_push;
    logic                      fifo_empty;
    logic                      fifo_full;
    logic [FIFODEPTH_LOG2:0]   fifo_count;
    logic                      accept;

    wm_fifo #(
        .DATAWIDTH      (DATAWIDTH),
        .FIFODEPTH      (FIFODEPTH),
        .FIFODEPTH_LOG2 (FIFODEPTH_LOG2)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (fifo_push),
        .pop   (accept),
        .din   (user_buffer_data),
        .dout  (master_writedata),
        .empty (fifo_empty),
        .full  (fifo_full),
        .count (fifo_count)
    );

    assign fifo_push         = user_write_buffer & ~fifo_full;
    assign user_buffer_full  = (fifo_count == CNT_DEPTH);
    assign aligned_length    = control_write_length & ALIGN_MASK;

    // Write request depends only on registered state so waitrequest never
    // feeds back combinationally into master_write.
    assign master_write      = (state_q == BUSY) & ~fifo_empty & (remaining_q != '0);
    assign accept            = master_write & ~master_waitrequest;
    assign master_address    = addr_q;
    assign master_byteenable = BYTEENABLEWIDTH'(be_all_ones(BYTEENABLEWIDTH));
    assign control_done      = (state_q == IDLE);

    // Leaving BUSY is decided from the next remaining value so control_done
    // rises the cycle right after the final word is accepted.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        remaining_d = remaining_q;
        fixed_d     = fixed_q;
        case (state_q)
            IDLE: begin
                if (control_go) begin
                    addr_d      = control_write_base;
                    remaining_d = aligned_length;
                    fixed_d     = control_fixed_location;
                    if (aligned_length != '0) begin
                        state_d = BUSY;
                    end
                end
            end
            BUSY: begin
                if (accept) begin
                    remaining_d = remaining_q - WORD_BYTES;
                    if (!fixed_q) begin
                        addr_d = addr_q + WORD_BYTES;
                    end
                end
                if (remaining_d == '0) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            remaining_q <= '0;
            fixed_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            remaining_q <= remaining_d;
            fixed_q     <= fixed_d;
        end
    end

endmodule

// File: tb/tb_avalon_write_master.sv
module tb_avalon_write_master;

    localparam int AW    = 28;
    localparam int DW    = 32;
    localparam int BEW   = 4;
    localparam int DEPTH = 32;
    localparam int LOG2  = 5;

    logic            clk;
    logic            reset;
    logic            control_fixed_location;
    logic [AW-1:0]   control_write_base;
    logic [AW-1:0]   control_write_length;
    logic            control_go;
    logic            control_done;
    logic            user_write_buffer;
    logic [DW-1:0]   user_buffer_data;
    logic            user_buffer_full;
    logic [AW-1:0]   master_address;
    logic            master_write;
    logic [BEW-1:0]  master_byteenable;
    logic [DW-1:0]   master_writedata;
    logic            master_waitrequest;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } exp_t;

    typedef struct {
        logic [AW-1:0] base;
        logic [AW-1:0] len;
        logic          fixed;
        logic [DW-1:0] first;
        int            expWords;
    } vec_t;

    exp_t sb[$];
    exp_t monE;
    int   checks;
    int   errors;
    int   acceptCount;

    avalon_write_master #(
        .ADDRESSWIDTH    (AW),
        .DATAWIDTH       (DW),
        .BYTEENABLEWIDTH (BEW),
        .FIFODEPTH       (DEPTH),
        .FIFODEPTH_LOG2  (LOG2)
    ) dut (
        .clk                    (clk),
        .reset                  (reset),
        .control_fixed_location (control_fixed_location),
        .control_write_base     (control_write_base),
        .control_write_length   (control_write_length),
        .control_go             (control_go),
        .control_done           (control_done),
        .user_write_buffer      (user_write_buffer),
        .user_buffer_data       (user_buffer_data),
        .user_buffer_full       (user_buffer_full),
        .master_address         (master_address),
        .master_write           (master_write),
        .master_byteenable      (master_byteenable),
        .master_writedata       (master_writedata),
        .master_waitrequest     (master_waitrequest)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic go, input logic [AW-1:0] base, input logic [AW-1:0] len,
                                 input logic fixed, input logic push, input logic [DW-1:0] data,
                                 input logic wr);
        control_go             = go;
        control_write_base     = base;
        control_write_length   = len;
        control_fixed_location = fixed;
        user_write_buffer      = push;
        user_buffer_data       = data;
        master_waitrequest     = wr;
    endtask

    task automatic idleInputs();
        applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, '0, 1'b0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard side: every accepted beat must match the oldest expectation.
    always @(negedge clk) begin
        if (reset === 1'b1 && master_write === 1'b1 && master_waitrequest === 1'b0) begin
            acceptCount++;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_write: got addr 0x%0h data 0x%0h, expected no write",
                         master_address, master_writedata);
            end else begin
                monE = sb.pop_front();
                checkOutput("wr_addr", 64'(master_address), 64'(monE.addr));
                checkOutput("wr_data", 64'(master_writedata), 64'(monE.data));
                checkOutput("wr_be", 64'(master_byteenable), 64'hF);
            end
        end
    end

    task automatic expectWrites(input logic [AW-1:0] base, input logic fixed,
                                input logic [DW-1:0] first, input int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            e.addr = base + (fixed ? AW'(0) : AW'(4 * i));
            e.data = first + DW'(i);
            sb.push_back(e);
        end
    endtask

    task automatic pushWords(input int n, input logic [DW-1:0] first);
        for (int i = 0; i < n; i++) begin
            applyStimulus(1'b0, '0, '0, 1'b0, 1'b1, first + DW'(i), 1'b0);
            tick();
        end
        idleInputs();
    endtask

    task automatic waitDone(input string name, input int budget);
        bit seen;
        seen = 1'b0;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            if (control_done === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        checkOutput({name, "_done"}, 64'(seen), 64'd1);
        tick();
        checkOutput({name, "_sb_empty"}, 64'(sb.size()), 64'd0);
    endtask

    task automatic runTransfer(input string name, input vec_t v);
        pushWords(v.expWords, v.first);
        applyStimulus(1'b1, v.base, v.len, v.fixed, 1'b0, '0, 1'b0);
        expectWrites(v.base, v.fixed, v.first, v.expWords);
        tick();
        idleInputs();
        waitDone(name, 200);
        checkOutput({name, "_fifo_cnt"}, 64'(dut.u_fifo.count), 64'd0);
    endtask

    vec_t vecs[5];
    int   a0;

    initial begin
        checks      = 0;
        errors      = 0;
        acceptCount = 0;
        reset       = 1'b0;
        idleInputs();

        vecs[0] = '{base: 28'h0000100, len: 28'd16, fixed: 1'b0, first: 32'd1,         expWords: 4};
        vecs[1] = '{base: 28'h0000200, len: 28'd12, fixed: 1'b1, first: 32'hA000_0000, expWords: 3};
        vecs[2] = '{base: 28'hFFFFFFC, len: 28'd8,  fixed: 1'b0, first: 32'h0000_00B0, expWords: 2};
        vecs[3] = '{base: 28'h0000300, len: 28'd10, fixed: 1'b0, first: 32'h0000_00C0, expWords: 2};
        vecs[4] = '{base: 28'h0000400, len: 28'd7,  fixed: 1'b0, first: 32'h0000_00C8, expWords: 1};

        // Reset state
        #2;
        checkOutput("rst_write", 64'(master_write), 64'd0);
        checkOutput("rst_done", 64'(control_done), 64'd1);
        checkOutput("rst_full", 64'(user_buffer_full), 64'd0);
        tick();
        tick();
        reset = 1'b1;
        tick();

        // Single word with go and push in the same cycle
        $display("[TB] single word");
        applyStimulus(1'b1, 28'h0000010, 28'd4, 1'b1, 1'b1, 32'hF00FBEEB, 1'b0);
        expectWrites(28'h0000010, 1'b1, 32'hF00FBEEB, 1);
        tick();
        idleInputs();
        @(negedge clk);
        checkOutput("single_c1_write", 64'(master_write), 64'd1);
        checkOutput("single_c1_done", 64'(control_done), 64'd0);
        checkOutput("single_c1_addr", 64'(master_address), 64'h10);
        tick();
        @(negedge clk);
        checkOutput("single_c2_done", 64'(control_done), 64'd1);
        checkOutput("single_c2_write", 64'(master_write), 64'd0);
        tick();

        // Waitrequest stall for 3 cycles
        $display("[TB] stall");
        a0 = acceptCount;
        applyStimulus(1'b1, 28'h0000010, 28'd4, 1'b1, 1'b1, 32'h1234_5678, 1'b1);
        expectWrites(28'h0000010, 1'b1, 32'h1234_5678, 1);
        tick();
        applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, '0, 1'b1);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checkOutput("stall_write", 64'(master_write), 64'd1);
            checkOutput("stall_addr", 64'(master_address), 64'h10);
            checkOutput("stall_data", 64'(master_writedata), 64'h1234_5678);
            checkOutput("stall_done", 64'(control_done), 64'd0);
            tick();
            if (k == 2) master_waitrequest = 1'b0;
        end
        @(negedge clk);
        checkOutput("stall_done_after", 64'(control_done), 64'd1);
        checkOutput("stall_accepts", 64'(acceptCount - a0), 64'd1);
        tick();

        // Table-driven transfers
        for (int i = 0; i < 5; i++) begin
            $display("[TB] vector %0d", i);
            runTransfer($sformatf("vec%0d", i), vecs[i]);
        end

        // Length zero: accepted but never leaves IDLE
        $display("[TB] length zero");
        applyStimulus(1'b1, 28'h0000700, 28'd0, 1'b0, 1'b0, '0, 1'b0);
        tick();
        idleInputs();
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checkOutput("len0_done", 64'(control_done), 64'd1);
            checkOutput("len0_write", 64'(master_write), 64'd0);
            tick();
        end

        // Go while BUSY is ignored; FIFO empty in BUSY just waits
        $display("[TB] go in busy");
        applyStimulus(1'b1, 28'h0000800, 28'd8, 1'b0, 1'b0, '0, 1'b0);
        expectWrites(28'h0000800, 1'b0, 32'h51, 2);
        tick();
        idleInputs();
        @(negedge clk);
        checkOutput("busy_done", 64'(control_done), 64'd0);
        checkOutput("busy_empty_write", 64'(master_write), 64'd0);
        tick();
        applyStimulus(1'b1, 28'h0000900, 28'd4, 1'b1, 1'b0, '0, 1'b0);
        tick();
        idleInputs();
        @(negedge clk);
        checkOutput("busy_go_ignored_addr", 64'(master_address), 64'h800);
        tick();
        pushWords(2, 32'h51);
        waitDone("busy", 50);

        // Fill to full, drop the 33rd word, then drain with a 128-byte transfer
        $display("[TB] full/drop");
        for (int i = 1; i <= 33; i++) begin
            applyStimulus(1'b0, '0, '0, 1'b0, 1'b1, DW'(i), 1'b0);
            tick();
            @(negedge clk);
            checkOutput($sformatf("full_after_%0d", i), 64'(user_buffer_full), (i >= 32) ? 64'd1 : 64'd0);
        end
        idleInputs();
        tick();
        checkOutput("full_count", 64'(dut.u_fifo.count), 64'd32);
        applyStimulus(1'b1, 28'h0001000, 28'd128, 1'b0, 1'b0, '0, 1'b0);
        expectWrites(28'h0001000, 1'b0, 32'd1, 32);
        tick();
        idleInputs();
        waitDone("drain", 100);
        checkOutput("drain_full", 64'(user_buffer_full), 64'd0);

        // Reset in the middle of a 4-word transfer after 2 accepted words
        $display("[TB] reset mid-transfer");
        pushWords(4, 32'hD0);
        a0 = acceptCount;
        applyStimulus(1'b1, 28'h0002000, 28'd16, 1'b0, 1'b0, '0, 1'b0);
        expectWrites(28'h0002000, 1'b0, 32'hD0, 4);
        tick();
        idleInputs();
        tick();
        tick();
        checkOutput("midrst_pre_write", 64'(master_write), 64'd1);
        reset = 1'b0;
        #1;
        checkOutput("midrst_write", 64'(master_write), 64'd0);
        checkOutput("midrst_done", 64'(control_done), 64'd1);
        checkOutput("midrst_count", 64'(dut.u_fifo.count), 64'd0);
        checkOutput("midrst_accepts", 64'(acceptCount - a0), 64'd2);
        sb.delete();
        tick();
        tick();
        reset = 1'b1;
        tick();
        runTransfer("post_reset", '{base: 28'h0003000, len: 28'd4, fixed: 1'b0, first: 32'hE0, expWords: 1});

        tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
